// File: rtl/switch_mcu_ifu_decode.sv
// Instruction fetch and decode stage of the switch MCU core.
// Owns the PC, fetches one instruction per period over a req/ack port,
// decodes RV32I+Zicsr into one-hot flags and holds them for a fixed
// execute window while counting cycles for the downstream ALU units.
//
// state | meaning
// ------+---------------------------------------------------------------
// FETCH | imem request asserted at PC, waiting for ack
// EXEC  | IR decoded, flags valid, cycle_cnt sweeps 0..EXEC_CYCLES-1
// HALT  | ebreak retired; idle until reset
module switch_mcu_ifu_decode #(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter int          EXEC_CYCLES = 4
) (
   input  logic        in_clk,
   input  logic        in_rst,
   output logic        out_imem_req,
   output logic [31:0] out_imem_addr,
   input  logic        in_imem_ack,
   input  logic [31:0] in_imem_rdata,
   input  logic        in_pc_load,
   input  logic [31:0] in_pc_next,
   output logic [31:0] out_pc_reg,
   output logic [3:0]  out_cycle_cnt,
   output logic        out_lui,
   output logic        out_auipc,
   output logic        out_jal,
   output logic        out_jalr,
   output logic        out_beq,
   output logic        out_bne,
   output logic        out_blt,
   output logic        out_bge,
   output logic        out_bltu,
   output logic        out_bgeu,
   output logic        out_lb,
   output logic        out_lh,
   output logic        out_lw,
   output logic        out_lbu,
   output logic        out_lhu,
   output logic        out_sb,
   output logic        out_sh,
   output logic        out_sw,
   output logic        out_addi,
   output logic        out_slti,
   output logic        out_sltiu,
   output logic        out_xori,
   output logic        out_ori,
   output logic        out_andi,
   output logic        out_slli,
   output logic        out_srli,
   output logic        out_srai,
   output logic        out_add,
   output logic        out_sub,
   output logic        out_sll,
   output logic        out_slt,
   output logic        out_sltu,
   output logic        out_xor,
   output logic        out_srl,
   output logic        out_sra,
   output logic        out_or,
   output logic        out_and,
   output logic        out_fence,
   output logic        out_fence_i,
   output logic        out_ecall,
   output logic        out_ebreak,
   output logic        out_csrrw,
   output logic        out_csrrs,
   output logic        out_csrrc,
   output logic        out_csrrwi,
   output logic        out_csrrsi,
   output logic        out_csrrci,
   output logic [4:0]  out_rs1,
   output logic [4:0]  out_rs2,
   output logic [4:0]  out_rd,
   output logic [11:0] out_imm_type_i,
   output logic [11:0] out_imm_type_s,
   output logic [11:0] out_imm_type_b,
   output logic [19:0] out_imm_type_u,
   output logic [18:0] out_imm_type_j,
   output logic        out_illegal,
   output logic        out_halted
);

   typedef enum logic [1:0] {
      S_FETCH = 2'd0,
      S_EXEC  = 2'd1,
      S_HALT  = 2'd2
   } state_t;

   localparam logic [3:0]  LAST_CNT   = 4'(EXEC_CYCLES - 1);
   localparam logic [31:0] INST_EBRK  = 32'h0010_0073;
   localparam logic [31:0] INST_ECALL = 32'h0000_0073;

   state_t      state_q, state_d;
   logic [31:0] pc_q;
   logic [31:0] ir_q;
   logic [3:0]  cnt_q;
   logic        pend_q;
   logic [31:0] pend_tgt_q;

   logic        last_cyc;
   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [6:0]  funct7;

   assign last_cyc = (state_q == S_EXEC) && (cnt_q == LAST_CNT);
   assign opcode   = ir_q[6:0];
   assign funct3   = ir_q[14:12];
   assign funct7   = ir_q[31:25];

   // State register
   always_ff @(posedge in_clk) begin
      if (!in_rst) state_q <= S_FETCH;
      else         state_q <= state_d;
   end

   // Next-state and fetch-port outputs
   always_comb begin
      state_d       = state_q;
      out_imem_req  = 1'b0;
      out_halted    = 1'b0;
      case (state_q)
         S_FETCH: begin
            out_imem_req = 1'b1;
            if (in_imem_ack) state_d = S_EXEC;
         end
         S_EXEC: begin
            if (last_cyc) state_d = (ir_q == INST_EBRK) ? S_HALT : S_FETCH;
         end
         S_HALT: begin
            out_halted = 1'b1;
         end
         default: state_d = S_FETCH;
      endcase
   end

   // PC, IR, cycle counter and pending-redirect registers
   always_ff @(posedge in_clk) begin
      if (!in_rst) begin
         pc_q       <= RESET_PC;
         ir_q       <= 32'h0;
         cnt_q      <= 4'd0;
         pend_q     <= 1'b0;
         pend_tgt_q <= 32'h0;
      end else begin
         if (state_q == S_FETCH && in_imem_ack) begin
            ir_q  <= in_imem_rdata;
            cnt_q <= 4'd0;
         end
         if (state_q == S_EXEC) begin
            if (in_pc_load) begin
               pend_q     <= 1'b1;
               pend_tgt_q <= in_pc_next & 32'hFFFF_FFFC;
            end
            if (last_cyc) begin
               // a redirect pulse in the final cycle still wins
               if (in_pc_load)  pc_q <= in_pc_next & 32'hFFFF_FFFC;
               else if (pend_q) pc_q <= pend_tgt_q;
               else             pc_q <= pc_q + 32'd4;
               pend_q <= 1'b0;
               cnt_q  <= 4'd0;
            end else begin
               cnt_q <= cnt_q + 4'd1;
            end
         end
      end
   end

   assign out_pc_reg     = pc_q;
   assign out_imem_addr  = pc_q;
   assign out_cycle_cnt  = cnt_q;
   assign out_rs1        = ir_q[19:15];
   assign out_rs2        = ir_q[24:20];
   assign out_rd         = ir_q[11:7];
   assign out_imm_type_i = ir_q[31:20];
   assign out_imm_type_s = {ir_q[31:25], ir_q[11:7]};
   assign out_imm_type_b = {ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8]};
   assign out_imm_type_u = ir_q[31:12];
   assign out_imm_type_j = {ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:22]};

   // One-hot decode of IR, only driven while executing
   always_comb begin
      out_lui = 1'b0;    out_auipc = 1'b0;  out_jal = 1'b0;    out_jalr = 1'b0;
      out_beq = 1'b0;    out_bne = 1'b0;    out_blt = 1'b0;    out_bge = 1'b0;
      out_bltu = 1'b0;   out_bgeu = 1'b0;
      out_lb = 1'b0;     out_lh = 1'b0;     out_lw = 1'b0;     out_lbu = 1'b0;
      out_lhu = 1'b0;
      out_sb = 1'b0;     out_sh = 1'b0;     out_sw = 1'b0;
      out_addi = 1'b0;   out_slti = 1'b0;   out_sltiu = 1'b0;  out_xori = 1'b0;
      out_ori = 1'b0;    out_andi = 1'b0;   out_slli = 1'b0;   out_srli = 1'b0;
      out_srai = 1'b0;
      out_add = 1'b0;    out_sub = 1'b0;    out_sll = 1'b0;    out_slt = 1'b0;
      out_sltu = 1'b0;   out_xor = 1'b0;    out_srl = 1'b0;    out_sra = 1'b0;
      out_or = 1'b0;     out_and = 1'b0;
      out_fence = 1'b0;  out_fence_i = 1'b0; out_ecall = 1'b0; out_ebreak = 1'b0;
      out_csrrw = 1'b0;  out_csrrs = 1'b0;  out_csrrc = 1'b0;
      out_csrrwi = 1'b0; out_csrrsi = 1'b0; out_csrrci = 1'b0;
      out_illegal = 1'b0;
      if (state_q == S_EXEC) begin
         case (opcode)
            7'b0110111: out_lui   = 1'b1;
            7'b0010111: out_auipc = 1'b1;
            7'b1101111: out_jal   = 1'b1;
            7'b1100111: begin
               if (funct3 == 3'b000) out_jalr = 1'b1;
               else                  out_illegal = 1'b1;
            end
            7'b1100011: begin
               case (funct3)
                  3'b000:  out_beq  = 1'b1;
                  3'b001:  out_bne  = 1'b1;
                  3'b100:  out_blt  = 1'b1;
                  3'b101:  out_bge  = 1'b1;
                  3'b110:  out_bltu = 1'b1;
                  3'b111:  out_bgeu = 1'b1;
                  default: out_illegal = 1'b1;
               endcase
            end
            7'b0000011: begin
               case (funct3)
                  3'b000:  out_lb  = 1'b1;
                  3'b001:  out_lh  = 1'b1;
                  3'b010:  out_lw  = 1'b1;
                  3'b100:  out_lbu = 1'b1;
                  3'b101:  out_lhu = 1'b1;
                  default: out_illegal = 1'b1;
               endcase
            end
            7'b0100011: begin
               case (funct3)
                  3'b000:  out_sb = 1'b1;
                  3'b001:  out_sh = 1'b1;
                  3'b010:  out_sw = 1'b1;
                  default: out_illegal = 1'b1;
               endcase
            end
            7'b0010011: begin
               case (funct3)
                  3'b000: out_addi  = 1'b1;
                  3'b010: out_slti  = 1'b1;
                  3'b011: out_sltiu = 1'b1;
                  3'b100: out_xori  = 1'b1;
                  3'b110: out_ori   = 1'b1;
                  3'b111: out_andi  = 1'b1;
                  3'b001: begin
                     if (funct7 == 7'b0000000) out_slli = 1'b1;
                     else                      out_illegal = 1'b1;
                  end
                  default: begin
                     if (funct7 == 7'b0000000)      out_srli = 1'b1;
                     else if (funct7 == 7'b0100000) out_srai = 1'b1;
                     else                           out_illegal = 1'b1;
                  end
               endcase
            end
            7'b0110011: begin
               if (funct7 == 7'b0000000) begin
                  case (funct3)
                     3'b000:  out_add  = 1'b1;
                     3'b001:  out_sll  = 1'b1;
                     3'b010:  out_slt  = 1'b1;
                     3'b011:  out_sltu = 1'b1;
                     3'b100:  out_xor  = 1'b1;
                     3'b101:  out_srl  = 1'b1;
                     3'b110:  out_or   = 1'b1;
                     default: out_and  = 1'b1;
                  endcase
               end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
                  out_sub = 1'b1;
               end else if (funct7 == 7'b0100000 && funct3 == 3'b101) begin
                  out_sra = 1'b1;
               end else begin
                  out_illegal = 1'b1;
               end
            end
            7'b0001111: begin
               if (funct3 == 3'b000)      out_fence   = 1'b1;
               else if (funct3 == 3'b001) out_fence_i = 1'b1;
               else                       out_illegal = 1'b1;
            end
            7'b1110011: begin
               case (funct3)
                  3'b000: begin
                     if (ir_q == INST_ECALL)     out_ecall   = 1'b1;
                     else if (ir_q == INST_EBRK) out_ebreak  = 1'b1;
                     else                        out_illegal = 1'b1;
                  end
                  3'b001:  out_csrrw  = 1'b1;
                  3'b010:  out_csrrs  = 1'b1;
                  3'b011:  out_csrrc  = 1'b1;
                  3'b101:  out_csrrwi = 1'b1;
                  3'b110:  out_csrrsi = 1'b1;
                  3'b111:  out_csrrci = 1'b1;
                  default: out_illegal = 1'b1;
               endcase
            end
            default: out_illegal = 1'b1;
         endcase
      end
   end

endmodule
